// File: rtl/address_req_pkg.sv
// Shared types and default sizes for the address request sequencer.
// Holds the operation/status encodings, the sequencer FSM states and the
// default address/index widths. Contains no logic of its own.
package address_req_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned INDEX_W_DEF = 3;
    localparam int unsigned STAT_W      = 16;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_ALLOC  = 2'd1,
        OP_FREE   = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_CONFLICT  = 2'd2,
        ST_FULL      = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PROBE  = 3'd1,
        S_COMMIT = 3'd2,
        S_SETTLE = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // The reserved opcode behaves exactly like a lookup.
    function automatic op_t decode_op(input logic [1:0] raw);
        return (raw == 2'd3) ? OP_LOOKUP : op_t'(raw);
    endfunction

endpackage

// File: rtl/address_req_sequencer_sat_counter.sv
// sat_counter: W-bit counter that increments on inc and sticks at all-ones.
// Ports: clock, reset (async, active-high), inc (count enable), count (value).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/address_req_sequencer.sv
// address_req_sequencer: turns LOOKUP / ALLOC / FREE requests into probe,
// write and clear sequences on an external address encoder and returns a
// status plus slot index per request. One request is in flight at a time.
// Ports:
//   clock, reset            single clock, async active-high reset
//   req_valid/ready/op/addr request channel (ready only while idle)
//   rsp_valid/ready/index/status  response channel, held until taken
//   enc_addr, enc_we, enc_clear   drive the encoder
//   enc_addr_out, enc_not_selected, enc_free_space  encoder lookup results
//   stat_ok_cnt, stat_err_cnt     response counters
// Build option: define STATS_EN to enable the saturating response counters;
// otherwise the stat ports read constant 0.
module address_req_sequencer
    import address_req_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INDEX_W = INDEX_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INDEX_W-1:0] rsp_index,
    output logic [1:0]         rsp_status,
    output logic [ADDR_W-1:0]  enc_addr,
    output logic               enc_we,
    output logic               enc_clear,
    input  logic [INDEX_W-1:0] enc_addr_out,
    input  logic               enc_not_selected,
    input  logic               enc_free_space,
    output logic [STAT_W-1:0]  stat_ok_cnt,
    output logic [STAT_W-1:0]  stat_err_cnt
);

    state_t state;
    op_t    op_q;

    // Sequencer FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= OP_LOOKUP;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_index  <= '0;
            rsp_status <= ST_OK;
            enc_addr   <= '0;
            enc_we     <= 1'b0;
            enc_clear  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= decode_op(req_op);
                        enc_addr  <= req_addr;
                        req_ready <= 1'b0;
                        state     <= S_PROBE;
                    end
                end

                // enc_addr has been stable for a full cycle; act on the lookup.
                S_PROBE: begin
                    case (op_q)
                        OP_ALLOC: begin
                            if (!enc_not_selected) begin
                                rsp_index  <= enc_addr_out;
                                rsp_status <= ST_CONFLICT;
                                rsp_valid  <= 1'b1;
                                state      <= S_RESP;
                            end else if (!enc_free_space) begin
                                rsp_index  <= '0;
                                rsp_status <= ST_FULL;
                                rsp_valid  <= 1'b1;
                                state      <= S_RESP;
                            end else begin
                                enc_we <= 1'b1;
                                state  <= S_COMMIT;
                            end
                        end
                        OP_FREE: begin
                            if (enc_not_selected) begin
                                rsp_index  <= '0;
                                rsp_status <= ST_NOT_FOUND;
                                rsp_valid  <= 1'b1;
                                state      <= S_RESP;
                            end else begin
                                // Slot index must be taken now: it vanishes once cleared.
                                rsp_index <= enc_addr_out;
                                enc_clear <= 1'b1;
                                state     <= S_COMMIT;
                            end
                        end
                        default: begin
                            rsp_index  <= enc_not_selected ? '0 : enc_addr_out;
                            rsp_status <= enc_not_selected ? ST_NOT_FOUND : ST_OK;
                            rsp_valid  <= 1'b1;
                            state      <= S_RESP;
                        end
                    endcase
                end

                S_COMMIT: begin
                    enc_we    <= 1'b0;
                    enc_clear <= 1'b0;
                    if (op_q == OP_ALLOC) begin
                        state <= S_SETTLE;
                    end else begin
                        rsp_status <= ST_OK;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end

                // The write landed at the end of COMMIT; the encoder now reports its slot.
                S_SETTLE: begin
                    rsp_index  <= enc_addr_out;
                    rsp_status <= ST_OK;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        enc_addr  <= '0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    rsp_valid <= 1'b0;
                    enc_we    <= 1'b0;
                    enc_clear <= 1'b0;
                    enc_addr  <= '0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STATS_EN
    // rsp_valid is only high in RESP, so valid&&ready marks the handshake.
    logic ok_fire_c;
    logic err_fire_c;

    assign ok_fire_c  = rsp_valid && rsp_ready && (rsp_status == ST_OK);
    assign err_fire_c = rsp_valid && rsp_ready && (rsp_status != ST_OK);

    sat_counter #(.W(STAT_W)) u_ok_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (ok_fire_c),
        .count (stat_ok_cnt)
    );

    sat_counter #(.W(STAT_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (err_fire_c),
        .count (stat_err_cnt)
    );
`else
    assign stat_ok_cnt  = '0;
    assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_address_req_sequencer.sv
// Testbench for address_req_sequencer. Provides an 8-entry address encoder
// model (lowest free slot on write, combinational match), predicts each
// response into a scoreboard queue when a request is driven and compares it
// when the response appears. Latency is counted with the accept edge as 1.
module tb_address_req_sequencer;
    import address_req_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned IW = 3;
    localparam int unsigned NENT = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [IW-1:0] rsp_index;
    logic [1:0]    rsp_status;
    logic [AW-1:0] enc_addr;
    logic          enc_we;
    logic          enc_clear;
    logic [IW-1:0] enc_addr_out;
    logic          enc_not_selected;
    logic          enc_free_space;
    logic [15:0]   stat_ok_cnt;
    logic [15:0]   stat_err_cnt;

    always #5 clock = ~clock;

    address_req_sequencer #(.ADDR_W(AW), .INDEX_W(IW)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_index        (rsp_index),
        .rsp_status       (rsp_status),
        .enc_addr         (enc_addr),
        .enc_we           (enc_we),
        .enc_clear        (enc_clear),
        .enc_addr_out     (enc_addr_out),
        .enc_not_selected (enc_not_selected),
        .enc_free_space   (enc_free_space),
        .stat_ok_cnt      (stat_ok_cnt),
        .stat_err_cnt     (stat_err_cnt)
    );

    // Encoder model: not reset by the sequencer's reset.
    bit          ent_vld  [NENT];
    bit [AW-1:0] ent_addr [NENT];

    always_comb begin
        enc_not_selected = 1'b1;
        enc_addr_out     = '0;
        enc_free_space   = 1'b0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (ent_vld[i] && (ent_addr[i] == enc_addr)) begin
                enc_not_selected = 1'b0;
                enc_addr_out     = IW'(i);
            end
            if (!ent_vld[i]) enc_free_space = 1'b1;
        end
    end

    always @(posedge clock) begin
        if (enc_we) begin
            for (int i = 0; i < NENT; i++) begin
                if (!ent_vld[i]) begin
                    ent_vld[i]  = 1'b1;
                    ent_addr[i] = enc_addr;
                    break;
                end
            end
        end
        if (enc_clear) begin
            for (int i = 0; i < NENT; i++) begin
                if (ent_vld[i] && ent_addr[i] == enc_addr) ent_vld[i] = 1'b0;
            end
        end
    end

    // Strobe pulse counters, sampled mid-cycle.
    int we_cnt = 0;
    int clr_cnt = 0;
    int both_cnt = 0;
    always @(negedge clock) begin
        if (enc_we) we_cnt++;
        if (enc_clear) clr_cnt++;
        if (enc_we && enc_clear) both_cnt++;
    end

    typedef struct {
        logic [1:0]    st;
        logic [IW-1:0] idx;
        int            lat;
        int            we;
        int            clr;
    } exp_t;

    exp_t sb [$];
    int n_cmp = 0;
    int n_bad = 0;
    int ok_cnt = 0;
    int err_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference prediction from the encoder contents before the request.
    function automatic exp_t predict(input logic [1:0] op, input logic [AW-1:0] a);
        exp_t e;
        int   hit = -1;
        int   fr = -1;
        for (int i = 0; i < NENT; i++) begin
            if (ent_vld[i] && ent_addr[i] == a && hit < 0) hit = i;
            if (!ent_vld[i] && fr < 0) fr = i;
        end
        e.we = 0; e.clr = 0; e.lat = 2; e.idx = '0;
        if (op == 2'd1) begin
            if (hit >= 0)      begin e.st = 2'(ST_CONFLICT); e.idx = IW'(hit); end
            else if (fr < 0)   begin e.st = 2'(ST_FULL); end
            else               begin e.st = 2'(ST_OK); e.idx = IW'(fr); e.lat = 4; e.we = 1; end
        end else if (op == 2'd2) begin
            if (hit < 0)       begin e.st = 2'(ST_NOT_FOUND); end
            else               begin e.st = 2'(ST_OK); e.idx = IW'(hit); e.lat = 3; e.clr = 1; end
        end else begin
            if (hit < 0)       begin e.st = 2'(ST_NOT_FOUND); end
            else               begin e.st = 2'(ST_OK); e.idx = IW'(hit); end
        end
        return e;
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] a,
                          input int hold, input logic early);
        exp_t          e;
        int            we0;
        int            clr0;
        int            lat;
        logic [1:0]    st0;
        logic [IW-1:0] ix0;
        sb.push_back(predict(op, a));
        we0  = we_cnt;
        clr0 = clr_cnt;
        @(negedge clock);
        req_op = op; req_addr = a; req_valid = 1'b1; rsp_ready = early;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        // Keep offering a different request while busy; it must be ignored.
        req_op = 2'd1; req_addr = 16'hBEEF;
        lat = 1;
        @(negedge clock);
        check_eq("req_ready_busy", 32'(req_ready), 32'd0);
        check_eq("enc_addr_hold", 32'(enc_addr), 32'(a));
        req_valid = 1'b0;
        while (!rsp_valid && lat < 20) begin
            lat++;
            @(negedge clock);
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            check_eq("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        check_eq("rsp_status", 32'(rsp_status), 32'(e.st));
        check_eq("rsp_index", 32'(rsp_index), 32'(e.idx));
        check_eq("latency", 32'(lat), 32'(e.lat));
        st0 = rsp_status;
        ix0 = rsp_index;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_status", 32'(rsp_status), 32'(st0));
            check_eq("hold_index", 32'(rsp_index), 32'(ix0));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        if (e.st == 2'(ST_OK)) ok_cnt++; else err_cnt++;
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_req_ready", 32'(req_ready), 32'd1);
        check_eq("post_enc_addr", 32'(enc_addr), 32'd0);
        check_eq("we_pulses", 32'(we_cnt - we0), 32'(e.we));
        check_eq("clr_pulses", 32'(clr_cnt - clr0), 32'(e.clr));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_index"}, 32'(rsp_index), 32'd0);
        check_eq({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
        check_eq({tag, "_enc_addr"}, 32'(enc_addr), 32'd0);
        check_eq({tag, "_enc_we"}, 32'(enc_we), 32'd0);
        check_eq({tag, "_enc_clear"}, 32'(enc_clear), 32'd0);
        check_eq({tag, "_stat_ok"}, 32'(stat_ok_cnt), 32'd0);
        check_eq({tag, "_stat_err"}, 32'(stat_err_cnt), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; rsp_ready = 1'b0;
        #1;
        check_reset_state("rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        do_req(2'd1, 16'd10, 0, 1'b0);            // OK idx 0, 4 cycles
        do_req(2'd1, 16'd10, 0, 1'b0);            // CONFLICT idx 0
        for (int k = 2; k <= 8; k++) do_req(2'd1, 16'(k * 10), 0, 1'b0);
        do_req(2'd1, 16'd90, 0, 1'b0);            // FULL
        do_req(2'd2, 16'd60, 0, 1'b0);            // FREE OK idx 5
        do_req(2'd1, 16'd90, 0, 1'b0);            // ALLOC OK idx 5
        do_req(2'd0, 16'd55, 0, 1'b0);            // NOT_FOUND
        do_req(2'd0, 16'd30, 5, 1'b0);            // OK idx 2, held 5 cycles
        do_req(2'd3, 16'd40, 0, 1'b1);            // op 3 as LOOKUP, early rsp_ready
        do_req(2'd2, 16'd90, 0, 1'b0);            // open slot 5 again

        // Reset in the middle of an ALLOC commit.
        @(negedge clock);
        req_op = 2'd1; req_addr = 16'd123; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #2;
        check_eq("we_in_commit", 32'(enc_we), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clock);
        reset = 1'b0;
        ok_cnt = 0;
        err_cnt = 0;

        do_req(2'd0, 16'd123, 0, 1'b0);           // write was aborted: NOT_FOUND
        do_req(2'd0, 16'd10, 0, 1'b0);            // OK idx 0
        do_req(2'd1, 16'd200, 0, 1'b1);           // OK idx 5, early rsp_ready
        do_req(2'd2, 16'd55, 0, 1'b0);            // NOT_FOUND
        do_req(2'd0, 16'd30, 0, 1'b0);            // OK idx 2

        @(negedge clock);
        check_eq("strobe_overlap", 32'(both_cnt), 32'd0);
`ifdef STATS_EN
        check_eq("stat_ok", 32'(stat_ok_cnt), 32'(ok_cnt));
        check_eq("stat_err", 32'(stat_err_cnt), 32'(err_cnt));
`else
        check_eq("stat_ok", 32'(stat_ok_cnt), 32'd0);
        check_eq("stat_err", 32'(stat_err_cnt), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
